gpio_irq: RTL and testbench

GPIO_IRQ -- requirements
Module: gpio_irq

---
 rtl/gpio_pkg.sv | 12 +
 rtl/gpio_irq_sync2.sv | 26 ++
 rtl/gpio_irq.sv | 96 +++++++++
 tb/tb_gpio_irq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO interrupt block: bus register map and arm-counter limit.
package gpio_pkg;

    localparam logic [1:0] ADDR_RISE_EN = 2'b00;
    localparam logic [1:0] ADDR_FALL_EN = 2'b01;
    localparam logic [1:0] ADDR_PENDING = 2'b10;
    localparam logic [1:0] ADDR_LEVEL   = 2'b11;

    // Edge detection becomes live once the arm counter saturates here.
    localparam logic [1:0] ARM_DONE     = 2'd3;

endpackage

// File: rtl/gpio_irq_sync2.sv
// Two-flop synchronizer bringing asynchronous pin levels into the clk domain.
module sync2 #(
    parameter int unsigned width = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] s1_q;
    logic [width-1:0] s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/gpio_irq.sv
// GPIO edge-interrupt controller: per-pin rise/fall enables, W1C pending bits, registered irq.
module gpio_irq
    import gpio_pkg::*;
#(
    parameter int unsigned npins = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [npins-1:0] pin_in,
    input  logic [npins-1:0] data_write,
    input  logic [1:0]       addr,
    input  logic             w_strobe,
    output logic [npins-1:0] data_read,
    output logic             irq
);

    logic [npins-1:0] s2;
    logic [npins-1:0] prev_q;
    logic [npins-1:0] rise_en_q,   rise_en_d;
    logic [npins-1:0] fall_en_q,   fall_en_d;
    logic [npins-1:0] pending_q,   pending_d;
    logic [npins-1:0] data_read_q, data_read_d;
    logic [1:0]       arm_q,       arm_d;
    logic             irq_q,       irq_d;

    logic             armed;
    logic [npins-1:0] rise;
    logic [npins-1:0] fall;
    logic [npins-1:0] set;
    logic [npins-1:0] clr;

    sync2 #(.width(npins)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pin_in),
        .q     (s2)
    );

    always_comb begin
        armed       = (arm_q == ARM_DONE);
        arm_d       = armed ? arm_q : arm_q + 2'd1;
        rise        = s2 & ~prev_q;
        fall        = ~s2 & prev_q;
        set         = armed ? ((rise & rise_en_q) | (fall & fall_en_q)) : '0;
        clr         = '0;
        rise_en_d   = rise_en_q;
        fall_en_d   = fall_en_q;
        data_read_d = '0;

        if (w_strobe) begin
            case (addr)
                ADDR_RISE_EN: rise_en_d = data_write;
                ADDR_FALL_EN: fall_en_d = data_write;
                ADDR_PENDING: clr       = data_write;
                default:      ;
            endcase
        end

        // Set is OR-ed in after the clear so a same-cycle edge wins over W1C.
        pending_d = (pending_q & ~clr) | set;

        case (addr)
            ADDR_RISE_EN: data_read_d = rise_en_q;
            ADDR_FALL_EN: data_read_d = fall_en_q;
            ADDR_PENDING: data_read_d = pending_q;
            ADDR_LEVEL:   data_read_d = s2;
            default:      data_read_d = '0;
        endcase

        irq_d = |pending_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q      <= '0;
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            pending_q   <= '0;
            data_read_q <= '0;
            arm_q       <= '0;
            irq_q       <= 1'b0;
        end else begin
            prev_q      <= s2;
            rise_en_q   <= rise_en_d;
            fall_en_q   <= fall_en_d;
            pending_q   <= pending_d;
            data_read_q <= data_read_d;
            arm_q       <= arm_d;
            irq_q       <= irq_d;
        end
    end

    assign data_read = data_read_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_gpio_irq.sv
// Bench for gpio_irq: directed register-map scenarios plus random traffic against a history-queue model.
module tb_gpio_irq;

    localparam int unsigned NP = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [NP-1:0] pin_in;
    logic [NP-1:0] data_write;
    logic [1:0]    addr;
    logic          w_strobe;
    logic [NP-1:0] data_read;
    logic          irq;

    always #5 clk = ~clk;

    gpio_irq #(.npins(NP)) dut (
        .clk        (clk),
        .reset      (reset),
        .pin_in     (pin_in),
        .data_write (data_write),
        .addr       (addr),
        .w_strobe   (w_strobe),
        .data_read  (data_read),
        .irq        (irq)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Model: smp[k] is the pin value sampled k edges ago; the synchronized level lags by two.
    logic [NP-1:0] m_rise, m_fall, m_pend, m_rd;
    logic          m_irq;
    logic [NP-1:0] smp[$];
    int            m_cyc;
    logic [NP-1:0] pin_v;

    task automatic model_edge(input logic rst, input logic [NP-1:0] pin, input logic [1:0] a,
                              input logic ws, input logic [NP-1:0] wd);
        logic [NP-1:0] lvl, old, set, clr;
        if (rst) begin
            m_rise = '0; m_fall = '0; m_pend = '0; m_rd = '0; m_irq = 1'b0;
            smp    = '{16'h0, 16'h0, 16'h0};
            m_cyc  = 0;
        end else begin
            lvl = smp[1];
            old = smp[2];
            set = (m_cyc >= 3) ? ((lvl & ~old & m_rise) | (~lvl & old & m_fall)) : '0;
            clr = (ws && a == 2'b10) ? wd : '0;
            case (a)
                2'b00:   m_rd = m_rise;
                2'b01:   m_rd = m_fall;
                2'b10:   m_rd = m_pend;
                default: m_rd = lvl;
            endcase
            m_irq  = (m_pend != 0);
            m_pend = (m_pend & ~clr) | set;
            if (ws && a == 2'b00) m_rise = wd;
            if (ws && a == 2'b01) m_fall = wd;
            smp.push_front(pin);
            void'(smp.pop_back());
            if (m_cyc < 3) m_cyc++;
        end
    endtask

    task automatic step(input logic rst, input logic [NP-1:0] pin, input logic [1:0] a,
                        input logic ws, input logic [NP-1:0] wd);
        reset = rst; pin_in = pin; addr = a; w_strobe = ws; data_write = wd;
        @(posedge clk);
        model_edge(rst, pin, a, ws, wd);
        @(negedge clk);
        check_eq("model_data_read", data_read, m_rd);
        check_eq("model_irq", irq, m_irq);
    endtask

    task automatic wr(input logic [1:0] a, input logic [NP-1:0] d);
        step(1'b0, pin_v, a, 1'b1, d);
    endtask

    task automatic rd(input logic [1:0] a);
        step(1'b0, pin_v, a, 1'b0, '0);
    endtask

    task automatic do_reset();
        step(1'b1, pin_v, 2'b10, 1'b0, '0);
        rd(2'b10); rd(2'b10); rd(2'b10);
    endtask

    initial begin
        pin_v = '0;
        step(1'b1, pin_v, 2'b00, 1'b0, '0);
        step(1'b1, pin_v, 2'b00, 1'b0, '0);
        check_eq("reset_data_read", data_read, 0);
        check_eq("reset_irq", irq, 0);

        // single rising edge on pin 0: pending at E2, irq at E3
        do_reset();
        wr(2'b00, 16'h0001);
        pin_v = 16'h0001;
        rd(2'b10); rd(2'b10);
        rd(2'b10);
        check_eq("rise_pend_e2", data_read, 0);
        check_eq("rise_irq_e2", irq, 0);
        rd(2'b10);
        check_eq("rise_pend_e3", data_read, 16'h0001);
        check_eq("rise_irq_e3", irq, 1);

        // falling edge on pin 15 only
        pin_v = 16'h8000;
        do_reset();
        wr(2'b01, 16'h8000);
        pin_v = 16'h0000;
        rd(2'b10); rd(2'b10); rd(2'b10); rd(2'b10);
        check_eq("fall_pend", data_read, 16'h8000);
        pin_v = 16'h8000;
        rd(2'b10); rd(2'b10); rd(2'b10); rd(2'b10);
        check_eq("fall_ignore_rise", data_read, 16'h8000);

        // W1C sequence on two pending bits
        pin_v = '0;
        do_reset();
        wr(2'b00, 16'h0003);
        pin_v = 16'h0003;
        rd(2'b10); rd(2'b10); rd(2'b10);
        wr(2'b10, 16'h0001);
        check_eq("w1c_prewrite_read", data_read, 16'h0003);
        wr(2'b10, 16'h0002);
        check_eq("w1c_after_first", data_read, 16'h0002);
        check_eq("w1c_irq_held", irq, 1);
        rd(2'b10);
        check_eq("w1c_after_second", data_read, 0);
        check_eq("w1c_irq_drop", irq, 0);

        // set beats clear on the same bit in the same cycle
        pin_v = '0;
        do_reset();
        wr(2'b00, 16'h0010);
        pin_v = 16'h0010;
        rd(2'b10); rd(2'b10);
        wr(2'b10, 16'h0010);
        rd(2'b10);
        check_eq("set_over_clear", data_read, 16'h0010);

        // pins high through reset must not look like edges
        pin_v = 16'hFFFF;
        step(1'b1, pin_v, 2'b10, 1'b0, '0);
        step(1'b1, pin_v, 2'b10, 1'b0, '0);
        wr(2'b00, 16'hFFFF);
        rd(2'b10); rd(2'b10); rd(2'b10); rd(2'b10); rd(2'b10);
        check_eq("no_false_edge_pend", data_read, 0);
        check_eq("no_false_edge_irq", irq, 0);

        // reset mid-operation discards pending
        pin_v = '0;
        do_reset();
        wr(2'b00, 16'h00F0);
        pin_v = 16'h00F0;
        rd(2'b10); rd(2'b10); rd(2'b10); rd(2'b10);
        check_eq("pre_reset_pend", data_read, 16'h00F0);
        step(1'b1, pin_v, 2'b10, 1'b0, '0);
        check_eq("midreset_data_read", data_read, 0);
        check_eq("midreset_irq", irq, 0);
        rd(2'b10);
        check_eq("post_reset_pend", data_read, 0);
        check_eq("post_reset_irq", irq, 0);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            logic          rst;
            logic [1:0]    a;
            logic          ws;
            logic [NP-1:0] wd;
            pin_v = pin_v ^ (NP'($urandom) & NP'($urandom) & NP'($urandom));
            rst   = ($urandom_range(0, 149) == 0);
            a     = 2'($urandom);
            ws    = ($urandom_range(0, 2) == 0);
            wd    = NP'($urandom);
            step(rst, pin_v, a, ws, wd);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
